// File: rtl/pixel_stream_unpacker.sv
// pixel_stream_unpacker
//   Receives the 32-bit packed RGB888 video stream (3 words carry 4 pixels),
//   unpacks it into one pixel per handshake, tracks the raster position and
//   checks SOF (tuser) / EOL (tlast) framing.
//
// Ports
//   aclk, areset          clock, asynchronous active-high reset
//   in_stream_t*          AXI4-Stream slave (tdata byte k = tdata[8k+7:8k])
//   pix_r/g/b, pix_x/y    presented pixel colour and raster position
//   pix_sof, pix_eol      pixel is (0,0) / pixel is the last of its line
//   pix_valid, pix_ready  pixel handshake
//   err_sof, err_eol      sticky framing error flags
//
// Build option
//   PIXEL_UNPACK_CHECK_EN  defined: framing checks, error flags and early-tlast
//                          line resync. Undefined: tlast ignored, tuser only
//                          resyncs to (0,0), error flags tied low.
//
// State | meaning
// ------+------------------------------------------------------------------
// FIRST | accepting words; each accepted word yields one pixel
// SECOND| ph2 word taken, P3 waits in the residue for the next pixel slot;
//       | the input is stalled until P3 is loaded into the output register
module pixel_stream_unpacker #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] in_stream_tdata,
    input  logic [3:0]  in_stream_tkeep,
    input  logic        in_stream_tlast,
    input  logic        in_stream_tuser,
    input  logic        in_stream_tvalid,
    output logic        in_stream_tready,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        err_sof,
    output logic        err_eol
);

    localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
    localparam logic [9:0] X_P2   = 10'(X_SIZE - 2);
    localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

    typedef enum logic {S_FIRST, S_SECOND} state_t;

    state_t      state, state_nxt;
    logic        run;
    logic [1:0]  ph, ph_nxt;
    logic [23:0] residue, residue_nxt;
    logic [9:0]  x_pos, x_pos_nxt;      // position of the next pixel produced
    logic [8:0]  y_pos, y_pos_nxt;
    logic        eol_pend, eol_pend_nxt;

    logic        out_free, accept, load, line_resync;
    logic [7:0]  ld_r, ld_g, ld_b;
    logic [9:0]  ld_x;
    logic [8:0]  ld_y;
    logic [1:0]  eff_ph;
    logic [9:0]  eff_x;
    logic [8:0]  eff_y;
    logic [7:0]  lane0, lane1, lane2, lane3;
    logic        unused_inputs;

    assign lane0 = in_stream_tdata[7:0];
    assign lane1 = in_stream_tdata[15:8];
    assign lane2 = in_stream_tdata[23:16];
    assign lane3 = in_stream_tdata[31:24];
    assign unused_inputs = ^{in_stream_tkeep, in_stream_tlast};

    // run holds tready low for the whole reset and the cycle it is released in
    assign out_free         = !pix_valid || pix_ready;
    assign in_stream_tready = run && (state == S_FIRST) && out_free;
    assign accept           = in_stream_tvalid && in_stream_tready;

    // tuser always restarts the frame; the word then unpacks as a ph0 word
    assign eff_ph = in_stream_tuser ? 2'd0  : ph;
    assign eff_x  = in_stream_tuser ? 10'd0 : x_pos;
    assign eff_y  = in_stream_tuser ? 9'd0  : y_pos;

    function automatic logic [8:0] y_step(input logic [8:0] y);
        return (y == Y_LAST) ? 9'd0 : y + 9'd1;
    endfunction

`ifdef PIXEL_UNPACK_CHECK_EN
    logic at_start, eol_exp, set_esof, set_eeol;

    assign at_start    = (x_pos == 10'd0) && (y_pos == 9'd0) && (ph == 2'd0);
    // tlast belongs on the ph2 word whose P3 lands on the last column
    assign eol_exp     = (eff_ph == 2'd2) && (eff_x == X_P2);
    assign line_resync = in_stream_tlast && !eol_exp;
    assign set_esof    = accept && (in_stream_tuser != at_start);
    assign set_eeol    = accept && (in_stream_tlast != eol_exp);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_sof <= 1'b0;
            err_eol <= 1'b0;
        end else begin
            if (set_esof) err_sof <= 1'b1;
            if (set_eeol) err_eol <= 1'b1;
        end
    end
`else
    assign line_resync = 1'b0;
    assign err_sof     = 1'b0;
    assign err_eol     = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        ph_nxt       = ph;
        residue_nxt  = residue;
        x_pos_nxt    = x_pos;
        y_pos_nxt    = y_pos;
        eol_pend_nxt = eol_pend;
        load         = 1'b0;
        ld_r         = 8'd0;
        ld_g         = 8'd0;
        ld_b         = 8'd0;
        ld_x         = x_pos;
        ld_y         = y_pos;
        case (state)
            S_FIRST: begin
                if (accept) begin
                    load = 1'b1;
                    ld_x = eff_x;
                    ld_y = eff_y;
                    case (eff_ph)
                        2'd0: begin
                            {ld_r, ld_g, ld_b} = {lane0, lane1, lane2};
                            residue_nxt        = {16'd0, lane3};
                            ph_nxt             = 2'd1;
                        end
                        2'd1: begin
                            {ld_r, ld_g, ld_b} = {residue[7:0], lane0, lane1};
                            residue_nxt        = {8'd0, lane3, lane2};
                            ph_nxt             = 2'd2;
                        end
                        default: begin
                            {ld_r, ld_g, ld_b} = {residue[7:0], residue[15:8], lane0};
                            residue_nxt        = {lane3, lane2, lane1};
                            state_nxt          = S_SECOND;
                            // an early tlast on a ph2 word takes effect after P3
                            eol_pend_nxt       = line_resync;
                        end
                    endcase
                    if (line_resync && (eff_ph != 2'd2)) begin
                        x_pos_nxt   = 10'd0;
                        y_pos_nxt   = y_step(eff_y);
                        ph_nxt      = 2'd0;
                        residue_nxt = 24'd0;
                    end else if (eff_x == X_LAST) begin
                        x_pos_nxt = 10'd0;
                        y_pos_nxt = y_step(eff_y);
                    end else begin
                        x_pos_nxt = eff_x + 10'd1;
                        y_pos_nxt = eff_y;
                    end
                end
            end
            S_SECOND: begin
                if (out_free) begin
                    load               = 1'b1;
                    {ld_r, ld_g, ld_b} = {residue[7:0], residue[15:8], residue[23:16]};
                    state_nxt          = S_FIRST;
                    ph_nxt             = 2'd0;
                    residue_nxt        = 24'd0;
                    eol_pend_nxt       = 1'b0;
                    if (eol_pend || (x_pos == X_LAST)) begin
                        x_pos_nxt = 10'd0;
                        y_pos_nxt = y_step(y_pos);
                    end else begin
                        x_pos_nxt = x_pos + 10'd1;
                    end
                end
            end
            default: state_nxt = S_FIRST;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= S_FIRST;
        else        state <= state_nxt;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            run      <= 1'b0;
            ph       <= 2'd0;
            residue  <= 24'd0;
            x_pos    <= 10'd0;
            y_pos    <= 9'd0;
            eol_pend <= 1'b0;
        end else begin
            run      <= 1'b1;
            ph       <= ph_nxt;
            residue  <= residue_nxt;
            x_pos    <= x_pos_nxt;
            y_pos    <= y_pos_nxt;
            eol_pend <= eol_pend_nxt;
        end
    end

    // load only happens when the slot is free, so a stalled pixel never changes
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pix_valid <= 1'b0;
            pix_r     <= 8'd0;
            pix_g     <= 8'd0;
            pix_b     <= 8'd0;
            pix_x     <= 10'd0;
            pix_y     <= 9'd0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
        end else if (load) begin
            pix_valid <= 1'b1;
            pix_r     <= ld_r;
            pix_g     <= ld_g;
            pix_b     <= ld_b;
            pix_x     <= ld_x;
            pix_y     <= ld_y;
            pix_sof   <= (ld_x == 10'd0) && (ld_y == 9'd0);
            pix_eol   <= (ld_x == X_LAST);
        end else if (pix_ready) begin
            pix_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_stream_unpacker.sv
module tb_pixel_stream_unpacker;

    localparam int XS = 640;
    localparam int YS = 8;
`ifdef PIXEL_UNPACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] in_stream_tdata = 32'd0;
    logic [3:0]  in_stream_tkeep = 4'hF;
    logic        in_stream_tlast = 1'b0;
    logic        in_stream_tuser = 1'b0;
    logic        in_stream_tvalid = 1'b0;
    logic        in_stream_tready;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof, pix_eol, pix_valid;
    logic        pix_ready = 1'b0;
    logic        err_sof, err_eol;

    int vectors = 0;
    int miscompares = 0;

    pixel_stream_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
        .aclk(aclk), .areset(areset),
        .in_stream_tdata(in_stream_tdata), .in_stream_tkeep(in_stream_tkeep),
        .in_stream_tlast(in_stream_tlast), .in_stream_tuser(in_stream_tuser),
        .in_stream_tvalid(in_stream_tvalid), .in_stream_tready(in_stream_tready),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .err_sof(err_sof), .err_eol(err_eol)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [7:0] r, g, b;
        logic [9:0] x;
        logic [8:0] y;
        logic       sof, eol;
    } pix_t;

    pix_t q[$];
    pix_t mon_p;

    // inputs change 1 time unit after posedge, so the negedge view is stable
    always @(negedge aclk) begin
        if (!areset && pix_valid && pix_ready) begin
            mon_p.r = pix_r; mon_p.g = pix_g; mon_p.b = pix_b;
            mon_p.x = pix_x; mon_p.y = pix_y;
            mon_p.sof = pix_sof; mon_p.eol = pix_eol;
            q.push_back(mon_p);
        end
    end

    // colour component c of frame pixel n
    function automatic logic [7:0] pcol(input int n, input int c);
        logic [7:0] lo, hi;
        lo = n[7:0];
        hi = n[15:8];
        case (c)
            0:       return lo;
            1:       return hi + 8'h40;
            default: return lo ^ 8'hA5;
        endcase
    endfunction

    // word k (0..2) of the group of four pixels starting at pixel n0
    function automatic logic [31:0] stream_word(input int n0, input int k);
        logic [31:0] w;
        int bi;
        w = 32'd0;
        for (int j = 0; j < 4; j++) begin
            bi = 4 * k + j;
            w[8*j +: 8] = pcol(n0 + bi / 3, bi % 3);
        end
        return w;
    endfunction

    task automatic drive_word(input logic [31:0] d, input logic u, input logic l);
        bit ok;
        ok = 1'b0;
        in_stream_tdata  = d;
        in_stream_tuser  = u;
        in_stream_tlast  = l;
        in_stream_tvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge aclk);
            if (in_stream_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL drive_word: tready stayed 0 for 200 cycles, required 1");
        end
        @(posedge aclk); #1;
        in_stream_tvalid = 1'b0;
        in_stream_tuser  = 1'b0;
        in_stream_tlast  = 1'b0;
    endtask

    task automatic send_group(input int n0, input bit u, input bit l);
        for (int k = 0; k < 3; k++)
            drive_word(stream_word(n0, k), u && (k == 0), l && (k == 2));
    endtask

    task automatic wait_pixels(input int n);
        for (int c = 0; c < 1000 && q.size() < n; c++) @(negedge aclk);
        vectors++;
        if (q.size() < n) begin
            miscompares++;
            $display("FAIL wait_pixels: got %0d pixels, required %0d", q.size(), n);
        end
    endtask

    task automatic do_reset();
        in_stream_tvalid = 1'b0;
        in_stream_tuser  = 1'b0;
        in_stream_tlast  = 1'b0;
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk); #1;
        q.delete();
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        vectors++;
        if ({pix_valid, in_stream_tready, pix_sof, pix_eol, err_sof, err_eol} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b required 000000",
                     {pix_valid, in_stream_tready, pix_sof, pix_eol, err_sof, err_eol});
        end
        vectors++;
        if ({pix_r, pix_g, pix_b, pix_x, pix_y} !== 43'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h required 0", {pix_r, pix_g, pix_b, pix_x, pix_y});
        end
        @(negedge aclk);
        areset = 1'b0;
        #1;
        vectors++;
        if (in_stream_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL tready_at_release: got %b required 0", in_stream_tready);
        end
        @(posedge aclk); #1;
        vectors++;
        if (in_stream_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL tready_after_release: got %b required 1", in_stream_tready);
        end
    endtask

    task automatic test_unpack_basic();
        logic [23:0] exp_rgb [4];
        exp_rgb = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        do_reset();
        pix_ready = 1'b1;
        drive_word(32'h44332211, 1'b1, 1'b0);
        vectors++;
        if ({pix_valid, pix_sof, pix_r, pix_x} !== {1'b1, 1'b1, 8'h11, 10'd0}) begin
            miscompares++;
            $display("FAIL first_pixel_latency: got v=%b sof=%b r=%h x=%0d required v=1 sof=1 r=11 x=0",
                     pix_valid, pix_sof, pix_r, pix_x);
        end
        drive_word(32'h88776655, 1'b0, 1'b0);
        drive_word(32'hCCBBAA99, 1'b0, 1'b0);
        @(negedge aclk);
        vectors++;
        if (in_stream_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL tready_second: got %b required 0", in_stream_tready);
        end
        @(negedge aclk);
        vectors++;
        if (in_stream_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL tready_after_second: got %b required 1", in_stream_tready);
        end
        wait_pixels(4);
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            vectors++;
            if ({q[i].r, q[i].g, q[i].b} !== exp_rgb[i] || q[i].x !== 10'(i) ||
                q[i].y !== 9'd0 || q[i].sof !== (i == 0) || q[i].eol !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_pixel%0d: got rgb=%h x=%0d y=%0d sof=%b eol=%b required rgb=%h x=%0d y=0 sof=%b eol=0",
                         i, {q[i].r, q[i].g, q[i].b}, q[i].x, q[i].y, q[i].sof, q[i].eol,
                         exp_rgb[i], i, (i == 0));
            end
        end
        vectors++;
        if ({err_sof, err_eol} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_errors: got %b required 00", {err_sof, err_eol});
        end
    endtask

    task automatic test_full_frame();
        int bad;
        do_reset();
        pix_ready = 1'b1;
        for (int y = 0; y < YS; y++)
            for (int g = 0; g < XS / 4; g++)
                send_group(y * XS + g * 4, (y == 0) && (g == 0), g == XS / 4 - 1);
        wait_pixels(XS * YS);
        vectors++;
        if (q.size() != XS * YS) begin
            miscompares++;
            $display("FAIL frame_count: got %0d required %0d", q.size(), XS * YS);
        end
        bad = 0;
        for (int i = 0; i < q.size() && i < XS * YS; i++) begin
            if (q[i].r !== pcol(i, 0) || q[i].g !== pcol(i, 1) || q[i].b !== pcol(i, 2) ||
                q[i].x !== 10'(i % XS) || q[i].y !== 9'(i / XS) ||
                q[i].sof !== (i == 0) || q[i].eol !== ((i % XS) == XS - 1))
                bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL frame_pixels: got %0d wrong pixels required 0", bad);
        end
        if (q.size() >= XS * YS) begin
            vectors++;
            if (q[XS*YS-1].x !== 10'(XS - 1) || q[XS*YS-1].y !== 9'(YS - 1) || q[XS*YS-1].eol !== 1'b1) begin
                miscompares++;
                $display("FAIL frame_last: got (%0d,%0d) eol=%b required (%0d,%0d) eol=1",
                         q[XS*YS-1].x, q[XS*YS-1].y, q[XS*YS-1].eol, XS - 1, YS - 1);
            end
        end
        vectors++;
        if ({err_sof, err_eol} !== 2'b00) begin
            miscompares++;
            $display("FAIL frame_errors: got %b required 00", {err_sof, err_eol});
        end
        q.delete();
        send_group(0, 1'b1, 1'b0);
        wait_pixels(4);
        if (q.size() > 0) begin
            vectors++;
            if (q[0].x !== 10'd0 || q[0].y !== 9'd0 || q[0].sof !== 1'b1 || {err_sof, err_eol} !== 2'b00) begin
                miscompares++;
                $display("FAIL next_frame: got (%0d,%0d) sof=%b err=%b required (0,0) sof=1 err=00",
                         q[0].x, q[0].y, q[0].sof, {err_sof, err_eol});
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        pix_ready = 1'b1;
        drive_word(32'h44332211, 1'b1, 1'b0);
        drive_word(32'h88776655, 1'b0, 1'b0);
        drive_word(32'hCCBBAA99, 1'b0, 1'b0);
        pix_ready        = 1'b0;
        in_stream_tdata  = 32'h0F0E0D0C;
        in_stream_tvalid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge aclk);
            vectors++;
            if ({pix_valid, pix_r, pix_g, pix_b, pix_x, in_stream_tready} !==
                {1'b1, 24'h778899, 10'd2, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_p2_c%0d: got v=%b rgb=%h x=%0d tready=%b required v=1 rgb=778899 x=2 tready=0",
                         c, pix_valid, {pix_r, pix_g, pix_b}, pix_x, in_stream_tready);
            end
            @(posedge aclk); #1;
        end
        pix_ready = 1'b1;
        @(negedge aclk);
        vectors++;
        if (in_stream_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_second_tready: got %b required 0", in_stream_tready);
        end
        @(posedge aclk); #1;
        pix_ready = 1'b0;
        @(negedge aclk);
        vectors++;
        if ({pix_valid, pix_r, pix_g, pix_b, pix_x, in_stream_tready} !==
            {1'b1, 24'hAABBCC, 10'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_p3: got v=%b rgb=%h x=%0d tready=%b required v=1 rgb=aabbcc x=3 tready=0",
                     pix_valid, {pix_r, pix_g, pix_b}, pix_x, in_stream_tready);
        end
        @(posedge aclk); #1;
        pix_ready = 1'b1;
        @(negedge aclk);
        vectors++;
        if (in_stream_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release_tready: got %b required 1", in_stream_tready);
        end
        @(posedge aclk); #1;
        in_stream_tvalid = 1'b0;
        pix_ready = 1'b0;
        @(negedge aclk);
        vectors++;
        if ({pix_valid, pix_r, pix_g, pix_b, pix_x} !== {1'b1, 24'h0C0D0E, 10'd4}) begin
            miscompares++;
            $display("FAIL stall_next_word: got v=%b rgb=%h x=%0d required v=1 rgb=0c0d0e x=4",
                     pix_valid, {pix_r, pix_g, pix_b}, pix_x);
        end
        vectors++;
        if (q.size() != 4) begin
            miscompares++;
            $display("FAIL stall_handshakes: got %0d required 4", q.size());
        end else begin
            vectors++;
            if ({q[2].r, q[2].g, q[2].b, q[3].r, q[3].g, q[3].b} !== 48'h778899AABBCC) begin
                miscompares++;
                $display("FAIL stall_order: got %h %h required 778899 aabbcc",
                         {q[2].r, q[2].g, q[2].b}, {q[3].r, q[3].g, q[3].b});
            end
        end
        pix_ready = 1'b1;
    endtask

    task automatic test_early_tlast();
        logic [9:0]  ex;
        logic [8:0]  ey;
        logic [23:0] ergb;
        do_reset();
        pix_ready = 1'b1;
        for (int g = 0; g < 33; g++) send_group(g * 4, g == 0, 1'b0);
        drive_word(stream_word(132, 0), 1'b0, 1'b0);
        drive_word(stream_word(132, 1), 1'b0, 1'b1);
        drive_word(stream_word(XS, 0), 1'b0, 1'b0);
        wait_pixels(135);
        ex   = CHK ? 10'd0 : 10'd134;
        ey   = CHK ? 9'd1  : 9'd0;
        ergb = CHK ? {pcol(XS, 0), pcol(XS, 1), pcol(XS, 2)}
                   : {pcol(134, 0), pcol(134, 1), pcol(XS, 0)};
        if (q.size() >= 135) begin
            vectors++;
            if (q[133].x !== 10'd133 || q[133].y !== 9'd0 || q[133].r !== pcol(133, 0)) begin
                miscompares++;
                $display("FAIL tlast_word_pixel: got (%0d,%0d) r=%h required (133,0) r=%h",
                         q[133].x, q[133].y, q[133].r, pcol(133, 0));
            end
            vectors++;
            if (q[134].x !== ex || q[134].y !== ey || {q[134].r, q[134].g, q[134].b} !== ergb) begin
                miscompares++;
                $display("FAIL tlast_next_pixel: got (%0d,%0d) rgb=%h required (%0d,%0d) rgb=%h",
                         q[134].x, q[134].y, {q[134].r, q[134].g, q[134].b}, ex, ey, ergb);
            end
        end
        vectors++;
        if ({err_eol, err_sof} !== {CHK, 1'b0}) begin
            miscompares++;
            $display("FAIL tlast_errors: got eol=%b sof=%b required eol=%b sof=0", err_eol, err_sof, CHK);
        end
    endtask

    task automatic test_midline_sof();
        do_reset();
        pix_ready = 1'b1;
        for (int y = 0; y < 5; y++)
            for (int g = 0; g < XS / 4; g++)
                send_group(y * XS + g * 4, (y == 0) && (g == 0), g == XS / 4 - 1);
        for (int g = 0; g < 80; g++) send_group(5 * XS + g * 4, 1'b0, 1'b0);
        drive_word(stream_word(0, 0), 1'b1, 1'b0);
        wait_pixels(5 * XS + 321);
        if (q.size() >= 5 * XS + 321) begin
            vectors++;
            if (q[5*XS+319].x !== 10'd319 || q[5*XS+319].y !== 9'd5) begin
                miscompares++;
                $display("FAIL sof_before: got (%0d,%0d) required (319,5)", q[5*XS+319].x, q[5*XS+319].y);
            end
            vectors++;
            if (q[5*XS+320].x !== 10'd0 || q[5*XS+320].y !== 9'd0 || q[5*XS+320].sof !== 1'b1 ||
                q[5*XS+320].r !== pcol(0, 0)) begin
                miscompares++;
                $display("FAIL sof_resync: got (%0d,%0d) sof=%b r=%h required (0,0) sof=1 r=%h",
                         q[5*XS+320].x, q[5*XS+320].y, q[5*XS+320].sof, q[5*XS+320].r, pcol(0, 0));
            end
        end
        vectors++;
        if ({err_sof, err_eol} !== {CHK, 1'b0}) begin
            miscompares++;
            $display("FAIL sof_errors: got sof=%b eol=%b required sof=%b eol=0", err_sof, err_eol, CHK);
        end
    endtask

    task automatic test_sof_missing();
        do_reset();
        pix_ready = 1'b1;
        drive_word(stream_word(0, 0), 1'b0, 1'b0);
        wait_pixels(1);
        vectors++;
        if ({err_sof, pix_x, pix_y} !== {CHK, 10'd0, 9'd0}) begin
            miscompares++;
            $display("FAIL sof_missing: got err_sof=%b (%0d,%0d) required err_sof=%b (0,0)",
                     err_sof, pix_x, pix_y, CHK);
        end
    endtask

    task automatic test_reset_second();
        do_reset();
        pix_ready = 1'b1;
        drive_word(32'h44332211, 1'b1, 1'b0);
        drive_word(32'h88776655, 1'b0, 1'b0);
        drive_word(32'hCCBBAA99, 1'b0, 1'b0);
        pix_ready = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        vectors++;
        if ({pix_valid, in_stream_tready, pix_sof, pix_r, pix_x} !== 21'd0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b tready=%b sof=%b r=%h x=%0d required all 0",
                     pix_valid, in_stream_tready, pix_sof, pix_r, pix_x);
        end
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk); #1;
        vectors++;
        if (in_stream_tready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_second_tready: got %b required 1", in_stream_tready);
        end
        q.delete();
        pix_ready = 1'b1;
        drive_word(32'h44332211, 1'b1, 1'b0);
        vectors++;
        if ({pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof} !==
            {1'b1, 24'h112233, 10'd0, 9'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_second_first_word: got v=%b rgb=%h (%0d,%0d) sof=%b required v=1 rgb=112233 (0,0) sof=1",
                     pix_valid, {pix_r, pix_g, pix_b}, pix_x, pix_y, pix_sof);
        end
    endtask

    initial begin
        test_reset();
        test_unpack_basic();
        test_full_frame();
        test_stall();
        test_early_tlast();
        test_midline_sof();
        test_sof_missing();
        test_reset_second();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
